bp_be_fe_queue_ckpt: RTL

//  Checkpointed FE->BE instruction queue; the stage directly upstream of the BE scheduler.

---
 rtl/bp_be_pkg.sv | 14 +
 rtl/bp_be_fe_queue_ptr.sv | 41 ++++
 rtl/bp_be_fe_queue_ckpt.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Back-end shared definitions used by the FE queue slice.
// Holds default geometry for the FE->BE queue and a pointer-width helper.
// The FE queue packet struct lives elsewhere and is passed as a flat vector.
package bp_be_pkg;

  localparam int unsigned fe_queue_width_lp = 128;
  localparam int unsigned fe_queue_els_lp   = 8;

  // Wrap-bit pointer width for a power-of-two queue of els entries.
  function automatic int unsigned fe_queue_ptr_width(input int unsigned els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// Wrap-bit pointer register for the checkpointed FE queue.
// Ports:
//   clk_i      - clock, rising edge
//   reset_i    - asynchronous active-high reset, pointer returns to 0
//   incr_i     - advance pointer by one (modulo 2^width_p)
//   load_i     - load load_val_i; takes priority over incr_i
//   load_val_i - value to load
//   ptr_o      - current pointer (MSB is the wrap bit)
module bp_be_fe_queue_ptr
  import bp_be_pkg::*;
#(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               incr_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i)
      ptr_d = load_val_i;
    else if (incr_i)
      ptr_d = ptr_q + width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed FE->BE instruction queue feeding the BE scheduler.
// The scheduler reads speculatively (yumi), then commits (deq), replays from
// the oldest uncommitted entry (roll) or discards everything (clr). A slot is
// only freed on deq.
// Ports:
//   clk_i / reset_i   - clock; asynchronous active-high reset
//   fe_queue_i/_v_i   - enqueue packet and valid from FE
//   fe_queue_ready_o  - not full, measured against the commit pointer
//   fe_queue_o/_v_o   - packet at speculative read pointer, and its valid
//   fe_queue_yumi_i   - scheduler consumed fe_queue_o
//   fe_queue_deq_i    - commit oldest read entry
//   fe_queue_roll_i   - rewind read pointer to commit pointer
//   fe_queue_clr_i    - discard all entries
//   fe_queue_empty_o  - no uncommitted or unread entries
module bp_be_fe_queue_ckpt
  import bp_be_pkg::*;
#(
  parameter int unsigned els_p         = fe_queue_els_lp,
  parameter int unsigned entry_width_p = fe_queue_width_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [entry_width_p-1:0] fe_queue_i,
  input  logic                     fe_queue_v_i,
  output logic                     fe_queue_ready_o,

  output logic [entry_width_p-1:0] fe_queue_o,
  output logic                     fe_queue_v_o,
  input  logic                     fe_queue_yumi_i,

  input  logic                     fe_queue_deq_i,
  input  logic                     fe_queue_roll_i,
  input  logic                     fe_queue_clr_i,
  output logic                     fe_queue_empty_o
);

  localparam int unsigned idx_w_lp = $clog2(els_p);
  localparam int unsigned ptr_w_lp = fe_queue_ptr_width(els_p);

  logic [ptr_w_lp-1:0] wptr, sptr, cptr, cptr_next;
  logic                full, enq;
  logic                s_load, s_incr, c_load, c_incr;
  logic [ptr_w_lp-1:0] s_load_val;

  assign full = (wptr[idx_w_lp-1:0] == cptr[idx_w_lp-1:0])
             && (wptr[idx_w_lp]     != cptr[idx_w_lp]);

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (sptr != wptr);
  assign fe_queue_empty_o = (wptr == cptr);

  assign enq = fe_queue_v_i & ~full & ~fe_queue_clr_i;

  // Roll rewinds to the commit point as it will be after this edge, so a
  // deq in the same cycle is already accounted for.
  assign cptr_next = fe_queue_deq_i ? cptr + ptr_w_lp'(1) : cptr;

  // clr > roll > yumi on the read pointer; deq is dropped under clr.
  always_comb begin
    s_load     = fe_queue_clr_i | fe_queue_roll_i;
    s_load_val = fe_queue_clr_i ? wptr : cptr_next;
    s_incr     = fe_queue_yumi_i;
    c_load     = fe_queue_clr_i;
    c_incr     = fe_queue_deq_i;
  end

  bp_be_fe_queue_ptr #(.width_p(ptr_w_lp)) wptr_reg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .incr_i     (enq),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (wptr)
  );

  bp_be_fe_queue_ptr #(.width_p(ptr_w_lp)) sptr_reg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .incr_i     (s_incr),
    .load_i     (s_load),
    .load_val_i (s_load_val),
    .ptr_o      (sptr)
  );

  bp_be_fe_queue_ptr #(.width_p(ptr_w_lp)) cptr_reg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .incr_i     (c_incr),
    .load_i     (c_load),
    .load_val_i (wptr),
    .ptr_o      (cptr)
  );

  // Flop storage, one write port and one async read port; contents not reset.
  logic [entry_width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wptr[idx_w_lp-1:0]] <= fe_queue_i;
  end

  assign fe_queue_o = mem_q[sptr[idx_w_lp-1:0]];

  // Protocol and pointer-ordering checks.
  logic [ptr_w_lp-1:0] dist_sc, dist_wc;
  assign dist_sc = sptr - cptr;
  assign dist_wc = wptr - cptr;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);

  a_deq_needs_read: assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_queue_deq_i && !fe_queue_clr_i) |-> (cptr != sptr));

  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_queue_v_i && !fe_queue_clr_i) |-> !full);

  a_ptr_order: assert property (@(posedge clk_i) disable iff (reset_i)
    (dist_sc <= dist_wc) && (dist_wc <= ptr_w_lp'(els_p)));

endmodule
